// File: rtl/pwm_multi_chan_if.sv
// Configuration write channel for pwm_multi_chan: valid/ready handshake
// carrying packed per-channel duties, the mode select and the divider.
interface pwm_multi_chan_if #(
  parameter int CHANNELS = 3,
  parameter int RES      = 7,
  parameter int PRESC_W  = 18
);
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [CHANNELS*RES-1:0]   cfg_duty;
  logic                      cfg_mode;
  logic [PRESC_W-1:0]        cfg_dvsr;

  modport master (output cfg_valid, cfg_duty, cfg_mode, cfg_dvsr, input cfg_ready);
  modport slave  (input cfg_valid, cfg_duty, cfg_mode, cfg_dvsr, output cfg_ready);
endinterface

// File: rtl/pwm_multi_chan.sv
// Multi-channel PWM generator: shared prescaler and duty counter, standard
// (duty-proportional) and servo (SERVO_BASE..2*SERVO_BASE tick) modes, and
// shadowed configuration that is applied only at a period boundary.
// Optional macro PWM_PHASE_STAGGER_EN offsets channel i's compare phase by
// i*(2^RES/CHANNELS) ticks to spread rising edges across the period.
module pwm_multi_chan #(
  parameter int CHANNELS      = 3,
  parameter int RES           = 7,
  parameter int PRESC_W       = 18,
  parameter int PRESC_DEFAULT = 10416,
  parameter int SERVO_BASE    = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  pwm_multi_chan_if.slave     cfg,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic                update_ack
);

  localparam logic [RES-1:0] D_MAX  = '1;
  localparam int             PROD_W = RES + 32;
`ifdef PWM_PHASE_STAGGER_EN
  localparam int STAGGER_STEP = (1 << RES) / CHANNELS;
`else
  localparam int STAGGER_STEP = 0;
`endif

  typedef struct packed {
    logic [CHANNELS*RES-1:0] duty;
    logic                    mode;
    logic [PRESC_W-1:0]      dvsr;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{duty: '0, mode: 1'b0, dvsr: PRESC_W'(PRESC_DEFAULT)};

  cfg_t                shadow_q, shadow_d;
  cfg_t                active_q, active_d;
  logic                pending_q, pending_d;
  logic [PRESC_W-1:0]  q_q, q_d;
  logic [RES-1:0]      d_q, d_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_start_q, update_ack_q;
  logic                tick, boundary, accept;

  // Output level of one channel for compare phase dp.
  function automatic logic chan_level(input logic [RES-1:0] dp,
                                      input logic [RES-1:0] duty,
                                      input logic           mode);
    logic [PROD_W-1:0] thr;
    // Product kept at full width so the shift sees every bit.
    thr = PROD_W'(SERVO_BASE) + ((PROD_W'(duty) * PROD_W'(SERVO_BASE)) >> RES);
    return mode ? (PROD_W'(dp) < thr) : (dp < duty);
  endfunction

  assign cfg.cfg_ready = ~pending_q;
  assign accept        = cfg.cfg_valid & ~pending_q;
  assign tick          = ena & (q_q == active_q.dvsr);
  assign boundary      = tick & (d_q == D_MAX);

  // Prescaler and duty counter; both held at zero while disabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    q_d = q_q + 1'b1;
    d_d = d_q;
    if (!ena) begin
      q_d = '0;
      d_d = '0;
    end else if (tick) begin
      q_d = '0;
      d_d = d_q + 1'b1;
    end
  end

  // Shadow capture on handshake, shadow-to-active copy on a pending boundary.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (accept) begin
      shadow_d  = '{duty: cfg.cfg_duty, mode: cfg.cfg_mode, dvsr: cfg.cfg_dvsr};
      pending_d = 1'b1;
    end else if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Per-channel compare against the (optionally staggered) counter phase.
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = chan_level(d_q + RES'(i * STAGGER_STEP),
                            active_q.duty[i*RES +: RES], active_q.mode);
    end
    if (!ena) pwm_d = '0;
  end

  // State and registered outputs; rst_n is active-high asynchronous here.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      q_q            <= '0;
      d_q            <= '0;
      // NOTE: the shadow is reset along with everything else so a reset mid-handshake discards it.
      shadow_q       <= '0;
      active_q       <= CFG_RESET;
      pending_q      <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      update_ack_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      q_q            <= q_d;
      d_q            <= d_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pwm_q          <= pwm_d;
      period_start_q <= boundary;
      update_ack_q   <= boundary & pending_q;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;
  assign update_ack   = update_ack_q;

endmodule
